// File: rtl/aggr_scheduler_if.sv
// Scheduler-side bundle: run control, WH BRAM read port, alpha FIFO pop, datapath strobes and status.
// Widths follow the scheduler parameters so both ends agree on every field.
interface aggr_scheduler_if #(
    parameter int NUM_NODE_WIDTH = 8,
    parameter int WH_ADDR_W      = 7,
    parameter int SG_CNT_W       = 12
);
    logic                      start_i;
    logic [SG_CNT_W-1:0]       num_sg_i;
    logic [WH_ADDR_W-1:0]      wh_bram_addrb;
    logic [NUM_NODE_WIDTH-1:0] wh_num_node_i;
    logic                      wh_src_flag_i;
    logic                      alpha_ff_empty;
    logic                      alpha_ff_rd_vld;
    logic                      acc_vld_o;
    logic                      acc_first_o;
    logic                      acc_last_o;
    logic                      res_vld_i;
    logic                      feat_rdy_i;
    logic [SG_CNT_W-1:0]       sg_idx_o;
    logic                      busy_o;
    logic                      done_o;
    logic                      err_o;

    modport master (
        input  start_i, num_sg_i, wh_num_node_i, wh_src_flag_i,
               alpha_ff_empty, res_vld_i, feat_rdy_i,
        output wh_bram_addrb, alpha_ff_rd_vld, acc_vld_o, acc_first_o,
               acc_last_o, sg_idx_o, busy_o, done_o, err_o
    );

    modport slave (
        output start_i, num_sg_i, wh_num_node_i, wh_src_flag_i,
               alpha_ff_empty, res_vld_i, feat_rdy_i,
        input  wh_bram_addrb, alpha_ff_rd_vld, acc_vld_o, acc_first_o,
               acc_last_o, sg_idx_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/aggr_scheduler.sv
// Walks the WH ring one subgraph at a time: header read/check, node streaming, result commit.
// Operand strobes lag the FIFO pop by 1 cycle; an empty FIFO or a low feat_rdy_i simply stalls.
module aggr_scheduler #(
    parameter int NUM_NODE_WIDTH = 8,
    parameter int WH_ADDR_W      = 7,
    parameter int SG_CNT_W       = 12
) (
    input  logic              clk,
    input  logic              rst,
    aggr_scheduler_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_CHK,
        STREAM,
        WAIT_RES,
        DONE
    } state_t;

    state_t                    state_q;
    logic [WH_ADDR_W-1:0]      addr_q;
    logic [WH_ADDR_W-1:0]      addr_d;
    logic [NUM_NODE_WIDTH-1:0] num_node_q;
    logic [NUM_NODE_WIDTH-1:0] node_cnt_q;
    logic [NUM_NODE_WIDTH-1:0] node_cnt_d;
    logic [SG_CNT_W-1:0]       num_sg_q;
    logic [SG_CNT_W-1:0]       sg_idx_q;
    logic [SG_CNT_W-1:0]       sg_idx_d;
    logic                      acc_vld_q;
    logic                      acc_first_q;
    logic                      acc_last_q;
    logic                      done_q;
    logic                      err_q;

    logic                      pop;
    logic                      last_node;
    logic                      last_sg;
    logic                      commit;
    logic                      hdr_ok;

    // The ring address wraps naturally at 2**WH_ADDR_W.
    assign addr_d     = addr_q + WH_ADDR_W'(1);
    assign node_cnt_d = node_cnt_q + NUM_NODE_WIDTH'(1);
    assign sg_idx_d   = sg_idx_q + SG_CNT_W'(1);

    // No pop may escape in the cycle a reset is being applied.
    assign pop       = !rst && (state_q == STREAM) && !bus.alpha_ff_empty;
    assign last_node = (node_cnt_q == num_node_q - NUM_NODE_WIDTH'(1));
    assign last_sg   = (sg_idx_q == num_sg_q - SG_CNT_W'(1));
    assign commit    = bus.res_vld_i && bus.feat_rdy_i;
    assign hdr_ok    = bus.wh_src_flag_i && (bus.wh_num_node_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            num_node_q  <= '0;
            node_cnt_q  <= '0;
            num_sg_q    <= '0;
            sg_idx_q    <= '0;
            acc_vld_q   <= 1'b0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            acc_vld_q   <= 1'b0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        if (bus.num_sg_i != '0) begin
                            num_sg_q <= bus.num_sg_i;
                            sg_idx_q <= '0;
                            err_q    <= 1'b0;
                            state_q  <= HDR_RD;
                        end else begin
                            done_q   <= 1'b1;
                        end
                    end
                end

                HDR_RD: begin
                    state_q <= HDR_CHK;
                end

                HDR_CHK: begin
                    if (hdr_ok) begin
                        num_node_q <= bus.wh_num_node_i;
                        node_cnt_q <= '0;
                        state_q    <= STREAM;
                    end else begin
                        err_q      <= 1'b1;
                        state_q    <= IDLE;
                    end
                end

                // The header word doubles as node 0, so streaming starts at the header address.
                STREAM: begin
                    if (pop) begin
                        addr_q      <= addr_d;
                        node_cnt_q  <= node_cnt_d;
                        acc_vld_q   <= 1'b1;
                        acc_first_q <= (node_cnt_q == '0);
                        acc_last_q  <= last_node;
                        if (last_node) begin
                            state_q <= WAIT_RES;
                        end
                    end
                end

                WAIT_RES: begin
                    if (commit) begin
                        if (last_sg) begin
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            sg_idx_q <= sg_idx_d;
                            state_q  <= HDR_RD;
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.wh_bram_addrb   = addr_q;
    assign bus.alpha_ff_rd_vld = pop;
    assign bus.acc_vld_o       = acc_vld_q;
    assign bus.acc_first_o     = acc_first_q;
    assign bus.acc_last_o      = acc_last_q;
    assign bus.sg_idx_o        = sg_idx_q;
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.done_o          = done_q;
    assign bus.err_o           = err_q;
endmodule

// File: tb/tb_aggr_scheduler.sv
// Directed bench for aggr_scheduler: a per-cycle vector table for a two-subgraph run,
// then hand sequences for FIFO stalls, ring wrap, result backpressure, header error and reset.
module tb_aggr_scheduler;
    localparam int NNW = 8;
    localparam int AW  = 7;
    localparam int SGW = 12;

    logic clk;
    logic rst;

    aggr_scheduler_if #(.NUM_NODE_WIDTH(NNW), .WH_ADDR_W(AW), .SG_CNT_W(SGW)) bus ();

    aggr_scheduler #(.NUM_NODE_WIDTH(NNW), .WH_ADDR_W(AW), .SG_CNT_W(SGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WH BRAM model: one-cycle read latency.
    logic [NNW-1:0] mem_nn  [0:(1<<AW)-1];
    logic           mem_src [0:(1<<AW)-1];

    always @(posedge clk) begin
        bus.wh_num_node_i <= mem_nn[bus.wh_bram_addrb];
        bus.wh_src_flag_i <= mem_src[bus.wh_bram_addrb];
    end

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic           st;
        logic [SGW-1:0] ns;
        logic           emp;
        logic           rv;
        logic           fr;
        logic           e_rd;
        logic [AW-1:0]  e_addr;
        logic           e_vld;
        logic           e_first;
        logic           e_last;
        logic [SGW-1:0] e_sg;
        logic           e_busy;
        logic           e_done;
        logic           e_err;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input int st, input int ns, input int emp, input int rv, input int fr,
                                input int rd, input int addr, input int vld, input int first,
                                input int last, input int sg, input int busy, input int done,
                                input int err);
        vec_t v;
        v.st      = (st != 0);
        v.ns      = SGW'(ns);
        v.emp     = (emp != 0);
        v.rv      = (rv != 0);
        v.fr      = (fr != 0);
        v.e_rd    = (rd != 0);
        v.e_addr  = AW'(addr);
        v.e_vld   = (vld != 0);
        v.e_first = (first != 0);
        v.e_last  = (last != 0);
        v.e_sg    = SGW'(sg);
        v.e_busy  = (busy != 0);
        v.e_done  = (done != 0);
        v.e_err   = (err != 0);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
    task automatic drive(input logic st, input int ns, input logic emp, input logic rv, input logic fr);
        bus.start_i        = st;
        bus.num_sg_i       = SGW'(ns);
        bus.alpha_ff_empty = emp;
        bus.res_vld_i      = rv;
        bus.feat_rdy_i     = fr;
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input int addr, input logic src, input int nn);
        mem_src[addr] = src;
        mem_nn[addr]  = NNW'(nn);
    endtask

    // One subgraph from its HDR_RD cycle through its first WAIT_RES cycle, FIFO never empty.
    task automatic do_sg(input int base, input int nn, input int sg, input logic commit);
        drive(0, 0, 0, 0, 0);
        chk($sformatf("sg@%0d hdr addr", base), 32'(bus.wh_bram_addrb), 32'(base));
        chk($sformatf("sg@%0d sg_idx", base), 32'(bus.sg_idx_o), 32'(sg));
        next();
        drive(0, 0, 0, 0, 0);
        chk($sformatf("sg@%0d chk rd", base), 32'(bus.alpha_ff_rd_vld), 32'd0);
        next();
        for (int i = 0; i < nn; i++) begin
            drive(0, 0, 0, 0, 0);
            chk($sformatf("sg@%0d n%0d rd", base, i), 32'(bus.alpha_ff_rd_vld), 32'd1);
            chk($sformatf("sg@%0d n%0d addr", base, i), 32'(bus.wh_bram_addrb), 32'((base + i) % 128));
            chk($sformatf("sg@%0d n%0d first", base, i), 32'(bus.acc_first_o), 32'(i == 1));
            chk($sformatf("sg@%0d n%0d last", base, i), 32'(bus.acc_last_o), 32'd0);
            next();
        end
        drive(0, 0, 0, commit, commit);
        chk($sformatf("sg@%0d wait rd", base), 32'(bus.alpha_ff_rd_vld), 32'd0);
        chk($sformatf("sg@%0d wait vld", base), 32'(bus.acc_vld_o), 32'd1);
        chk($sformatf("sg@%0d wait last", base), 32'(bus.acc_last_o), 32'd1);
        chk($sformatf("sg@%0d wait first", base), 32'(bus.acc_first_o), 32'(nn == 1));
        next();
    endtask

    initial begin
        int e_emp [8] = '{0, 1, 1, 0, 0, 0, 0, 0};
        int e_rd  [8] = '{1, 0, 0, 1, 1, 1, 0, 0};
        int e_adr [8] = '{4, 5, 5, 5, 6, 7, 8, 8};
        int e_vld [8] = '{0, 1, 0, 0, 1, 1, 1, 0};
        int vld_cnt;

        for (int a = 0; a < 128; a++) begin
            mem_nn[a]  = '0;
            mem_src[a] = 1'b0;
        end
        rst = 1'b1;
        drive(0, 0, 1, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("reset rd", 32'(bus.alpha_ff_rd_vld), 32'd0);
        chk("reset addr", 32'(bus.wh_bram_addrb), 32'd0);
        chk("reset vld", 32'(bus.acc_vld_o), 32'd0);
        chk("reset first", 32'(bus.acc_first_o), 32'd0);
        chk("reset last", 32'(bus.acc_last_o), 32'd0);
        chk("reset sg", 32'(bus.sg_idx_o), 32'd0);
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        chk("reset done", 32'(bus.done_o), 32'd0);
        chk("reset err", 32'(bus.err_o), 32'd0);
        next();

        // Zero-subgraph start, then two subgraphs (3 nodes at 0, 1 node at 3).
        set_hdr(0, 1'b1, 3);
        set_hdr(3, 1'b1, 1);
        //            st ns em rv fr | rd ad vl fi la sg bu dn er
        tbl[0]  = mk(1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(1, 2, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 1,   1, 1, 1, 1, 0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0,   1, 2, 1, 0, 0, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 1,   0, 3, 1, 0, 1, 0, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 1, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0,   1, 3, 0, 0, 0, 1, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 1,   0, 4, 1, 1, 1, 1, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0,   0, 4, 0, 0, 0, 1, 1, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0,   0, 4, 0, 0, 0, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 1, 0, 0,   0, 4, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].st, int'(tbl[i].ns), tbl[i].emp, tbl[i].rv, tbl[i].fr);
            chk($sformatf("tbl[%0d] rd", i), 32'(bus.alpha_ff_rd_vld), 32'(tbl[i].e_rd));
            chk($sformatf("tbl[%0d] addr", i), 32'(bus.wh_bram_addrb), 32'(tbl[i].e_addr));
            chk($sformatf("tbl[%0d] vld", i), 32'(bus.acc_vld_o), 32'(tbl[i].e_vld));
            chk($sformatf("tbl[%0d] first", i), 32'(bus.acc_first_o), 32'(tbl[i].e_first));
            chk($sformatf("tbl[%0d] last", i), 32'(bus.acc_last_o), 32'(tbl[i].e_last));
            chk($sformatf("tbl[%0d] sg", i), 32'(bus.sg_idx_o), 32'(tbl[i].e_sg));
            chk($sformatf("tbl[%0d] busy", i), 32'(bus.busy_o), 32'(tbl[i].e_busy));
            chk($sformatf("tbl[%0d] done", i), 32'(bus.done_o), 32'(tbl[i].e_done));
            chk($sformatf("tbl[%0d] err", i), 32'(bus.err_o), 32'(tbl[i].e_err));
            next();
        end

        // FIFO empty for 2 cycles at node 1 of 4 (header at 4).
        set_hdr(4, 1'b1, 4);
        drive(1, 1, 0, 0, 0);
        next();
        drive(0, 0, 0, 0, 0);
        chk("stall hdr addr", 32'(bus.wh_bram_addrb), 32'd4);
        next();
        drive(0, 0, 0, 0, 0);
        next();
        vld_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, e_emp[k][0], k == 7, k == 7);
            chk($sformatf("stall c%0d rd", k), 32'(bus.alpha_ff_rd_vld), 32'(e_rd[k]));
            chk($sformatf("stall c%0d addr", k), 32'(bus.wh_bram_addrb), 32'(e_adr[k]));
            chk($sformatf("stall c%0d vld", k), 32'(bus.acc_vld_o), 32'(e_vld[k]));
            if (bus.acc_vld_o === 1'b1) vld_cnt++;
            next();
        end
        chk("stall vld count", 32'(vld_cnt), 32'd4);
        drive(0, 0, 0, 0, 0);
        chk("stall done", 32'(bus.done_o), 32'd1);
        next();

        // Ring wrap: 118 nodes from 8, then 4 nodes at 126 -> 127, 0, 1; next header at 2.
        set_hdr(8, 1'b1, 118);
        set_hdr(126, 1'b1, 4);
        set_hdr(2, 1'b1, 2);
        drive(1, 3, 0, 0, 0);
        chk("wrap start busy", 32'(bus.busy_o), 32'd0);
        next();
        do_sg(8, 118, 0, 1'b1);
        do_sg(126, 4, 1, 1'b1);
        do_sg(2, 2, 2, 1'b0);
        // Result ready but feature controller stalled for 5 cycles.
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 0);
            chk($sformatf("bp c%0d sg", k), 32'(bus.sg_idx_o), 32'd2);
            chk($sformatf("bp c%0d busy", k), 32'(bus.busy_o), 32'd1);
            chk($sformatf("bp c%0d done", k), 32'(bus.done_o), 32'd0);
            chk($sformatf("bp c%0d rd", k), 32'(bus.alpha_ff_rd_vld), 32'd0);
            next();
        end
        drive(0, 0, 0, 1, 1);
        chk("bp commit addr", 32'(bus.wh_bram_addrb), 32'd4);
        next();
        drive(0, 0, 0, 0, 0);
        chk("bp done", 32'(bus.done_o), 32'd1);
        chk("bp done sg", 32'(bus.sg_idx_o), 32'd2);
        next();
        drive(0, 0, 0, 0, 0);
        chk("bp idle busy", 32'(bus.busy_o), 32'd0);
        chk("bp idle done", 32'(bus.done_o), 32'd0);
        next();

        // Bad header (src flag clear) at 4.
        set_hdr(4, 1'b0, 5);
        drive(1, 1, 0, 0, 0);
        next();
        drive(0, 0, 0, 0, 0);
        next();
        drive(0, 0, 0, 0, 0);
        chk("err chk err", 32'(bus.err_o), 32'd0);
        next();
        drive(0, 0, 0, 0, 0);
        chk("err set", 32'(bus.err_o), 32'd1);
        chk("err busy", 32'(bus.busy_o), 32'd0);
        chk("err done", 32'(bus.done_o), 32'd0);
        next();
        drive(0, 0, 0, 0, 0);
        chk("err sticky", 32'(bus.err_o), 32'd1);
        chk("err no done", 32'(bus.done_o), 32'd0);
        chk("err addr held", 32'(bus.wh_bram_addrb), 32'd4);
        next();
        set_hdr(4, 1'b1, 1);
        drive(1, 1, 0, 0, 0);
        chk("err at start", 32'(bus.err_o), 32'd1);
        next();
        drive(0, 0, 0, 0, 0);
        chk("err cleared", 32'(bus.err_o), 32'd0);
        do_sg(4, 1, 0, 1'b1);
        drive(0, 0, 0, 0, 0);
        chk("err rerun done", 32'(bus.done_o), 32'd1);
        next();

        // Reset mid-stream at node 2 of the second subgraph.
        set_hdr(5, 1'b1, 1);
        set_hdr(6, 1'b1, 4);
        drive(1, 2, 0, 0, 0);
        next();
        do_sg(5, 1, 0, 1'b1);
        drive(0, 0, 0, 0, 0);
        chk("rst hdr addr", 32'(bus.wh_bram_addrb), 32'd6);
        next();
        drive(0, 0, 0, 0, 0);
        next();
        drive(0, 0, 0, 0, 0);
        next();
        drive(0, 0, 0, 0, 0);
        next();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("rst cycle rd", 32'(bus.alpha_ff_rd_vld), 32'd0);
        chk("rst cycle addr", 32'(bus.wh_bram_addrb), 32'd8);
        chk("rst cycle sg", 32'(bus.sg_idx_o), 32'd1);
        next();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("post rst rd", 32'(bus.alpha_ff_rd_vld), 32'd0);
        chk("post rst addr", 32'(bus.wh_bram_addrb), 32'd0);
        chk("post rst vld", 32'(bus.acc_vld_o), 32'd0);
        chk("post rst first", 32'(bus.acc_first_o), 32'd0);
        chk("post rst last", 32'(bus.acc_last_o), 32'd0);
        chk("post rst sg", 32'(bus.sg_idx_o), 32'd0);
        chk("post rst busy", 32'(bus.busy_o), 32'd0);
        chk("post rst done", 32'(bus.done_o), 32'd0);
        chk("post rst err", 32'(bus.err_o), 32'd0);
        next();
        drive(0, 0, 0, 0, 0);
        chk("post rst no done", 32'(bus.done_o), 32'd0);
        next();
        set_hdr(0, 1'b1, 1);
        drive(1, 1, 0, 0, 0);
        next();
        do_sg(0, 1, 0, 1'b1);
        drive(0, 0, 0, 0, 0);
        chk("post rst run done", 32'(bus.done_o), 32'd1);
        next();
        drive(0, 0, 0, 0, 0);
        chk("post rst run idle", 32'(bus.busy_o), 32'd0);
        chk("post rst run addr", 32'(bus.wh_bram_addrb), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
